instruction_encoder: RTL
========================

INSTRUCTION_ENCODER -- requirements
Module: instruction_encoder

Interface
REQ-001 Parameter: BASE_ADDR, 64'h0, byte address of the first emitted word.
REQ-002 clk  input  1  system clock; all state updates on rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 in_valid  input  1  request fields valid.
REQ-005 in_ready  output  1  encoder can accept a request.
REQ-006 fmt  input  2  format: 2'b00 I, 2'b01 S, 2'b11 SB, 2'b10 unsupported.
REQ-007 opcode  input  7  copied to instr[6:0].
REQ-008 funct3  input  3  copied to instr[14:12].
REQ-009 rd, rs1, rs2  input  5 each  register fields.
REQ-010 imm  input  64  signed immediate, byte offset for SB.
REQ-011 out_valid  output  1  instr/addr valid.
REQ-012 out_ready  input  1  consumer accepts the word.
REQ-013 instr  output  32  encoded instruction word.
REQ-014 addr  output  64  byte address of instr.
REQ-015 err_pulse  output  1  one-cycle pulse on a rejected request.
REQ-016 err_count  output  8  saturating count of rejected requests.

Function
REQ-017 FSM states: IDLE, ENC, OUT. in_ready is 1 only in IDLE.
REQ-018 IDLE: in_valid=1 registers all input fields and moves to ENC. Otherwise stays in IDLE.
REQ-019 ENC, fmt=I: instr = {imm[11:0], rs1, funct3, rd, opcode}.
REQ-020 ENC, fmt=S: instr = {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode}.
REQ-021 ENC, fmt=SB: instr = {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], opcode}.
REQ-022 Range rule, I/S: imm[63:11] all equal (range -2048..2047).
REQ-023 Range rule, SB: imm[63:12] all equal and imm[0]=0 (range -4096..4094, even).
REQ-024 Valid request in ENC: instr is registered and the FSM moves to OUT. Latency from accept to out_valid is 2 cycles.
REQ-025 Range violation or fmt=2'b10 in ENC: err_pulse=1 for one cycle, err_count increments (saturates at 255), no word is emitted, addr is unchanged, FSM returns to IDLE.
REQ-026 OUT: out_valid=1. instr and addr are held stable until out_ready=1.
REQ-027 OUT with out_ready=1: FSM returns to IDLE and addr increments by 4 after the handshake.
REQ-028 addr wraps modulo 2^64 with no flag.
REQ-029 Simultaneous in_valid and out_ready in OUT: only the output handshake completes; the input is not accepted (in_ready=0).
REQ-030 in_valid deasserted while in_ready=0 is legal; there is no request queue.

Reset
REQ-031 reset=1 asynchronously forces: state=IDLE, in_ready=1, out_valid=0, instr=32'h0, addr=BASE_ADDR, err_pulse=0, err_count=0.
REQ-032 Reset mid-operation (ENC or OUT) discards the pending word and does not count an error.
REQ-033 First accepted request after reset release is sampled on the first rising edge with reset=0.

Structure
REQ-034 Shared package holds: FMT_I=2'b00, FMT_S=2'b01, FMT_SB=2'b11, FMT_BAD=2'b10, state encoding, ADDR_STEP=4.
REQ-035 Combinational sub-module imm_range_check (inputs fmt, imm; output ok) implements REQ-022/023 and is instantiated once.
REQ-036 Encoding muxes, FSM, address counter and error counter reside in instruction_encoder.

Verification
REQ-037 I type: fmt=00, opcode=7'h03, rd=5, rs1=2, funct3=3, imm=-8 -> after 2 cycles instr=32'hFF813283, addr=BASE_ADDR, out_valid=1.
REQ-038 S type: fmt=01, opcode=7'h23, rs1=2, rs2=5, funct3=3, imm=16, out_ready=1 -> instr=32'h00513823, next addr=BASE_ADDR+4.
REQ-039 SB type: fmt=11, opcode=7'h63, rs1=1, rs2=2, funct3=0, imm=-4 -> instr=32'hFE208EE3. Decoding the word with the team's decoder returns imm[11:1] and sign matching -4.
REQ-040 Range errors: SB imm=3 (odd), I imm=2048, fmt=10 -> three err_pulse, err_count=3, no out_valid, addr unchanged.
REQ-041 Backpressure and reset: hold out_ready=0 for 5 cycles -> instr/addr stable, in_ready=0. Assert reset in OUT -> out_valid=0 immediately, addr=BASE_ADDR, err_count unchanged at 0.
REQ-042 Saturation: 260 bad requests -> err_count=255.

Source files
------------

// File: rtl/instruction_encoder_pkg.sv
// Shared definitions for the instruction encoder: field widths, format codes,
// FSM state encoding, address step and the registered request payload.
package instruction_encoder_pkg;

    localparam int unsigned XLEN  = 64;
    localparam int unsigned ILEN  = 32;
    localparam int unsigned FMT_W = 2;
    localparam int unsigned OPC_W = 7;
    localparam int unsigned F3_W  = 3;
    localparam int unsigned REG_W = 5;
    localparam int unsigned ERR_W = 8;

    localparam logic [FMT_W-1:0] FMT_I   = 2'b00;
    localparam logic [FMT_W-1:0] FMT_S   = 2'b01;
    localparam logic [FMT_W-1:0] FMT_SB  = 2'b11;
    localparam logic [FMT_W-1:0] FMT_BAD = 2'b10;

    localparam logic [XLEN-1:0] ADDR_STEP = 64'd4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_ENC  = 2'b01,
        ST_OUT  = 2'b10
    } state_e;

    // Request fields captured on accept
    typedef struct packed {
        logic [FMT_W-1:0] fmt;
        logic [OPC_W-1:0] opcode;
        logic [F3_W-1:0]  funct3;
        logic [REG_W-1:0] rd;
        logic [REG_W-1:0] rs1;
        logic [REG_W-1:0] rs2;
        logic [XLEN-1:0]  imm;
    } enc_req_t;

endpackage

// File: rtl/instruction_encoder_imm_range_check.sv
// imm_range_check: combinational immediate range/format legality check.
// Ports:
//   fmt - instruction format code
//   imm - 64-bit signed immediate (byte offset for SB)
//   ok  - 1 when the immediate fits the format and the format is supported
module imm_range_check
    import instruction_encoder_pkg::*;
(
    input  logic [FMT_W-1:0] fmt,
    input  logic [XLEN-1:0]  imm,
    output logic             ok
);

    logic fits12;
    logic fits13;
    logic unused_imm_mid;

    // Upper bits must be pure sign extension of the encodable field
    assign fits12 = (&imm[XLEN-1:11]) | ~(|imm[XLEN-1:11]);
    assign fits13 = (&imm[XLEN-1:12]) | ~(|imm[XLEN-1:12]);

    // Middle bits never affect legality
    assign unused_imm_mid = ^imm[10:1];

    always_comb begin
        ok = 1'b0;
        case (fmt)
            FMT_I, FMT_S: ok = fits12;
            FMT_SB:       ok = fits13 & ~imm[0];
            default:      ok = 1'b0;
        endcase
    end

endmodule

// File: rtl/instruction_encoder.sv
// instruction_encoder: accepts one I/S/SB request at a time, encodes it into a
// 32-bit instruction word and presents it with its byte address; illegal
// requests are dropped with an error pulse and a saturating error count.
// Ports:
//   clk, reset            - clock, async active-high reset
//   in_valid / in_ready   - request handshake
//   fmt, opcode, funct3,
//   rd, rs1, rs2, imm     - request fields
//   out_valid / out_ready - output word handshake
//   instr, addr           - encoded word and its byte address
//   err_pulse, err_count  - rejected-request pulse and saturating count
module instruction_encoder
    import instruction_encoder_pkg::*;
#(
    parameter logic [XLEN-1:0] BASE_ADDR = 64'h0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [FMT_W-1:0] fmt,
    input  logic [OPC_W-1:0] opcode,
    input  logic [F3_W-1:0]  funct3,
    input  logic [REG_W-1:0] rd,
    input  logic [REG_W-1:0] rs1,
    input  logic [REG_W-1:0] rs2,
    input  logic [XLEN-1:0]  imm,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ILEN-1:0]  instr,
    output logic [XLEN-1:0]  addr,
    output logic             err_pulse,
    output logic [ERR_W-1:0] err_count
);

    state_e           state_q, state_d;
    enc_req_t         req_q, req_d;
    logic [ILEN-1:0]  instr_q, instr_d;
    logic [XLEN-1:0]  addr_q, addr_d;
    logic [ERR_W-1:0] err_cnt_q, err_cnt_d;
    logic             err_pulse_q, err_pulse_d;
    logic             out_valid_q, out_valid_d;
    logic             in_ready_q, in_ready_d;
    logic [ILEN-1:0]  enc_word;
    logic             range_ok;

    imm_range_check u_range (
        .fmt (req_q.fmt),
        .imm (req_q.imm),
        .ok  (range_ok)
    );

    // Encoding mux on the captured request
    always_comb begin
        enc_word = '0;
        case (req_q.fmt)
            FMT_I:   enc_word = {req_q.imm[11:0], req_q.rs1, req_q.funct3,
                                 req_q.rd, req_q.opcode};
            FMT_S:   enc_word = {req_q.imm[11:5], req_q.rs2, req_q.rs1,
                                 req_q.funct3, req_q.imm[4:0], req_q.opcode};
            FMT_SB:  enc_word = {req_q.imm[12], req_q.imm[10:5], req_q.rs2,
                                 req_q.rs1, req_q.funct3, req_q.imm[4:1],
                                 req_q.imm[11], req_q.opcode};
            default: enc_word = '0;
        endcase
    end

    // Next-state and datapath updates
    always_comb begin
        state_d     = state_q;
        req_d       = req_q;
        instr_d     = instr_q;
        addr_d      = addr_q;
        err_cnt_d   = err_cnt_q;
        err_pulse_d = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    req_d.fmt    = fmt;
                    req_d.opcode = opcode;
                    req_d.funct3 = funct3;
                    req_d.rd     = rd;
                    req_d.rs1    = rs1;
                    req_d.rs2    = rs2;
                    req_d.imm    = imm;
                    state_d      = ST_ENC;
                end
            end
            ST_ENC: begin
                if (range_ok) begin
                    instr_d = enc_word;
                    state_d = ST_OUT;
                end else begin
                    err_pulse_d = 1'b1;
                    if (err_cnt_q != {ERR_W{1'b1}}) begin
                        err_cnt_d = err_cnt_q + ERR_W'(1);
                    end
                    state_d = ST_IDLE;
                end
            end
            ST_OUT: begin
                // Word and address hold until the consumer takes them
                if (out_ready) begin
                    addr_d  = addr_q + ADDR_STEP;
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        out_valid_d = (state_d == ST_OUT);
        in_ready_d  = (state_d == ST_IDLE);
    end

    // State and output registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            req_q       <= '0;
            instr_q     <= '0;
            addr_q      <= BASE_ADDR;
            err_cnt_q   <= '0;
            err_pulse_q <= 1'b0;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
        end else begin
            state_q     <= state_d;
            req_q       <= req_d;
            instr_q     <= instr_d;
            addr_q      <= addr_d;
            err_cnt_q   <= err_cnt_d;
            err_pulse_q <= err_pulse_d;
            out_valid_q <= out_valid_d;
            in_ready_q  <= in_ready_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign instr     = instr_q;
    assign addr      = addr_q;
    assign err_pulse = err_pulse_q;
    assign err_count = err_cnt_q;

endmodule
